command_executor: RTL and testbench
===================================

COMMAND_EXECUTOR -- requirements
Module: command_executor

Interface
REQ-001 SHALL have parameter c_signal_width, default 32, width of period/count/width fields.
REQ-002 SHALL have parameter c_instruction_width, default 4, width of instruction field.
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits fetching new commands.
REQ-006 SHALL have port clear_status  input  1  clears sticky underrun.
REQ-007 SHALL have port remove_buffer_empty  input  1  command FIFO empty.
REQ-008 SHALL have port remove_signal  output  1  FIFO read request, one-cycle pulse.
REQ-009 SHALL have ports remove_instruction/remove_pulse_period/remove_pulse_count/remove_pulse_width  input  4/32/32/32  FIFO read data.
REQ-010 SHALL have port pulse_out  output  1  step pulse to motor driver.
REQ-011 SHALL have port direction_out  output  1  instruction bit 0 of the active command.
REQ-012 SHALL have ports busy  output  1  command in progress; command_done  output  1  one-cycle completion strobe; underrun  output  1  sticky starvation flag.

Function
REQ-013 SHALL implement FSM IDLE -> FETCH -> LOAD -> RUN -> (FETCH | IDLE).
REQ-014 IDLE: SHALL enter FETCH when enable=1 and remove_buffer_empty=0.
REQ-015 FETCH: SHALL assert remove_signal for exactly this one cycle; never when remove_buffer_empty=1.
REQ-016 LOAD: SHALL capture all four FIFO data fields (valid one cycle after read request) and update direction_out.
REQ-017 Period 0 SHALL be treated as 1; width SHALL be clamped to period-1.
REQ-018 Count 0 SHALL skip RUN: command_done asserted in LOAD cycle, no pulses.
REQ-019 RUN: phase counter SHALL count 0..period-1, then wrap and increment pulse counter.
REQ-020 pulse_out SHALL be 1 when instruction bit 1=1 (PULSE) and phase < clamped width; always 0 for DWELL.
REQ-021 Instruction bits 2-3 SHALL be ignored.
REQ-022 RUN SHALL end after count full periods; command_done asserted on final RUN cycle.
REQ-023 After final RUN cycle SHALL go to FETCH if enable=1 and FIFO non-empty (fixed 2-cycle inter-command gap), else IDLE.
REQ-024 Completion with enable=1 and FIFO empty SHALL set underrun; held until reset or clear_status; set wins over simultaneous clear.
REQ-025 enable deasserted mid-command SHALL let the active command finish, then go IDLE.
REQ-026 direction_out SHALL hold its value after completion until next LOAD.
REQ-027 busy SHALL be 1 in FETCH, LOAD, RUN; 0 in IDLE.
REQ-028 Counters SHALL be c_signal_width unsigned; count of 2^32-1 SHALL execute fully without overflow.

Reset
REQ-029 reset SHALL take priority over all inputs, including mid-command, and abort the command without command_done.
REQ-030 After reset: state IDLE; remove_signal, pulse_out, direction_out, busy, command_done, underrun all 0; counters 0.

Configuration
REQ-031 With COMMAND_EXECUTOR_POSITION_EN defined SHALL add port position output 32 signed, reset 0, +1 per PULSE-mode pulse rising edge when direction_out=0, -1 when 1, two's-complement wrap.
REQ-032 Without COMMAND_EXECUTOR_POSITION_EN the position port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package menlo_cnc_pkg SHALL hold instruction bit indices (DIRECTION=0, ACTION=1), default widths, and the FSM state enum.
REQ-034 Phase/pulse counting SHALL live in sub-module pulse_phase_counter (load, run, period, width, count in; pulse_active, last_cycle out).

Verification
REQ-035 Load (2,4,4,1), enable=1 -> remove_signal 1 cycle, direction_out=0, 4 pulses each 1 cycle high every 4 cycles, command_done after 16 RUN cycles, then underrun=1.
REQ-036 (3,4,16,4) -> direction_out=1 from LOAD, width clamped: 16 pulses, 3 high/1 low.
REQ-037 Two queued DWELL (0,4,16,4) -> pulse_out stays 0, busy for 2x(2+64) cycles continuously, two command_done strobes.
REQ-038 (2,0,0,5) -> no pulses, command_done in LOAD cycle, busy for 2 cycles.
REQ-039 reset asserted mid-RUN of (2,4,4,1) -> next cycle IDLE, all outputs 0, no command_done; clear_status clears underrun.
REQ-040 With COMMAND_EXECUTOR_POSITION_EN: (2,4,4,1) then (3,4,16,1) -> position 4 then -12.

Source files
------------

// File: rtl/menlo_cnc_pkg.sv
// Shared definitions for the CNC command path: instruction bit positions,
// default field widths and the command executor state encoding.
package menlo_cnc_pkg;

    localparam int DIRECTION           = 0;
    localparam int ACTION              = 1;
    localparam int C_SIGNAL_WIDTH      = 32;
    localparam int C_INSTRUCTION_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_RUN
    } exec_state_t;

endpackage

// File: rtl/command_executor_pulse_phase_counter.sv
// Phase/pulse counter for one command: captures period, width and count on
// load, then walks the phase through each period while run is high.
module pulse_phase_counter #(
    parameter int c_signal_width = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_load,
    input  logic                      i_run,
    input  logic [c_signal_width-1:0] i_period,
    input  logic [c_signal_width-1:0] i_width,
    input  logic [c_signal_width-1:0] i_count,
    output logic                      o_pulse_active,
    output logic                      o_last_cycle
);

    logic [c_signal_width-1:0] w_period_eff;
    logic [c_signal_width-1:0] w_width_eff;
    logic [c_signal_width-1:0] r_period;
    logic [c_signal_width-1:0] r_width;
    logic [c_signal_width-1:0] r_count;
    logic [c_signal_width-1:0] r_phase;
    logic [c_signal_width-1:0] r_pulses;

    // A zero period behaves as one cycle, and the high time always leaves a low cycle.
    assign w_period_eff = (i_period == '0) ? c_signal_width'(1) : i_period;
    assign w_width_eff  = (i_width < w_period_eff) ? i_width : w_period_eff - c_signal_width'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_period <= '0;
            r_width  <= '0;
            r_count  <= '0;
            r_phase  <= '0;
            r_pulses <= '0;
        end else if (i_load) begin
            r_period <= w_period_eff;
            r_width  <= w_width_eff;
            r_count  <= i_count;
            r_phase  <= '0;
            r_pulses <= '0;
        end else if (i_run) begin
            if (r_phase == r_period - c_signal_width'(1)) begin
                r_phase  <= '0;
                r_pulses <= r_pulses + c_signal_width'(1);
            end else begin
                r_phase <= r_phase + c_signal_width'(1);
            end
        end
    end

    assign o_pulse_active = (r_phase < r_width);
    assign o_last_cycle   = (r_phase == r_period - c_signal_width'(1)) &&
                            (r_pulses == r_count - c_signal_width'(1));

endmodule

// File: rtl/command_executor.sv
// Fetches step/dwell commands from a FIFO and plays them out as pulse trains.
// Define COMMAND_EXECUTOR_POSITION_EN to add the signed step position output.
module command_executor
    import menlo_cnc_pkg::*;
#(
    parameter int c_signal_width      = C_SIGNAL_WIDTH,
    parameter int c_instruction_width = C_INSTRUCTION_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           clear_status,
    input  logic                           remove_buffer_empty,
    output logic                           remove_signal,
    input  logic [c_instruction_width-1:0] remove_instruction,
    input  logic [c_signal_width-1:0]      remove_pulse_period,
    input  logic [c_signal_width-1:0]      remove_pulse_count,
    input  logic [c_signal_width-1:0]      remove_pulse_width,
    output logic                           pulse_out,
    output logic                           direction_out,
    output logic                           busy,
    output logic                           command_done,
    output logic                           underrun
`ifdef COMMAND_EXECUTOR_POSITION_EN
    ,
    output logic signed [31:0]             position
`endif
);

    exec_state_t r_state;
    exec_state_t w_next_state;

    logic w_fifo_ready;
    logic w_count_zero;
    logic w_load;
    logic w_run;
    logic w_pulse_active;
    logic w_last_cycle;
    logic w_unused_instr;
    logic r_direction;
    logic r_action;
    logic r_underrun;

    assign w_fifo_ready   = enable && !remove_buffer_empty;
    assign w_count_zero   = (remove_pulse_count == '0);
    assign w_unused_instr = ^remove_instruction;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_fifo_ready) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = remove_buffer_empty ? ST_IDLE : ST_LOAD;
            ST_LOAD: begin
                if (!w_count_zero)     w_next_state = ST_RUN;
                else if (w_fifo_ready) w_next_state = ST_FETCH;
                else                   w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (w_last_cycle) w_next_state = w_fifo_ready ? ST_FETCH : ST_IDLE;
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        remove_signal = 1'b0;
        command_done  = 1'b0;
        busy          = 1'b1;
        w_load        = 1'b0;
        w_run         = 1'b0;
        case (r_state)
            ST_IDLE:  busy = 1'b0;
            ST_FETCH: remove_signal = !remove_buffer_empty;
            ST_LOAD: begin
                w_load       = 1'b1;
                command_done = w_count_zero;
            end
            ST_RUN: begin
                w_run        = 1'b1;
                command_done = w_last_cycle;
            end
            default:  busy = 1'b0;
        endcase
    end

    pulse_phase_counter #(
        .c_signal_width (c_signal_width)
    ) u_counter (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_load         (w_load),
        .i_run          (w_run),
        .i_period       (remove_pulse_period),
        .i_width        (remove_pulse_width),
        .i_count        (remove_pulse_count),
        .o_pulse_active (w_pulse_active),
        .o_last_cycle   (w_last_cycle)
    );

    // Underrun is sticky; a new starvation event beats a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_direction <= 1'b0;
            r_action    <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_direction <= remove_instruction[DIRECTION];
                r_action    <= remove_instruction[ACTION];
            end
            if (command_done && enable && remove_buffer_empty) r_underrun <= 1'b1;
            else if (clear_status)                            r_underrun <= 1'b0;
        end
    end

    assign pulse_out     = w_run && r_action && w_pulse_active;
    assign direction_out = r_direction;
    assign underrun      = r_underrun;

`ifdef COMMAND_EXECUTOR_POSITION_EN
    logic               r_pulse_prev;
    logic signed [31:0] r_position;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pulse_prev <= 1'b0;
            r_position   <= '0;
        end else begin
            r_pulse_prev <= pulse_out;
            if (pulse_out && !r_pulse_prev) begin
                r_position <= direction_out ? r_position - 32'sd1 : r_position + 32'sd1;
            end
        end
    end

    assign position = r_position;
`endif

endmodule

// File: tb/tb_command_executor.sv
// Self-checking bench for command_executor: directed scenarios plus random
// commands, checked cycle by cycle against a per-command expansion model.
module tb_command_executor;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_status;
    logic        remove_buffer_empty;
    logic        remove_signal;
    logic [3:0]  remove_instruction;
    logic [31:0] remove_pulse_period;
    logic [31:0] remove_pulse_count;
    logic [31:0] remove_pulse_width;
    logic        pulse_out;
    logic        direction_out;
    logic        busy;
    logic        command_done;
    logic        underrun;
`ifdef COMMAND_EXECUTOR_POSITION_EN
    logic signed [31:0] position;
`endif

    always #5 clock = ~clock;

    command_executor dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .clear_status        (clear_status),
        .remove_buffer_empty (remove_buffer_empty),
        .remove_signal       (remove_signal),
        .remove_instruction  (remove_instruction),
        .remove_pulse_period (remove_pulse_period),
        .remove_pulse_count  (remove_pulse_count),
        .remove_pulse_width  (remove_pulse_width),
        .pulse_out           (pulse_out),
        .direction_out       (direction_out),
        .busy                (busy),
        .command_done        (command_done),
        .underrun            (underrun)
`ifdef COMMAND_EXECUTOR_POSITION_EN
        ,
        .position            (position)
`endif
    );

    typedef struct {
        logic busy;
        logic rs;
        logic pulse;
        logic done;
        logic setDir;
        logic dirVal;
    } cyc_t;

    typedef struct {
        logic [3:0]  instr;
        logic [31:0] period;
        logic [31:0] count;
        logic [31:0] width;
    } cmd_t;

    cyc_t expQ[$];
    cmd_t fifoQ[$];
    cmd_t modelQ[$];

    int   total = 0;
    int   bad = 0;
    int   doneSeen = 0;
    int   expPos = 0;
    logic expDir = 1'b0;
    logic expUnder = 1'b0;
    logic prevExpPulse = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pushCmd(input logic [3:0] i, input logic [31:0] p, input logic [31:0] c,
                           input logic [31:0] w);
        cmd_t cmd;
        cmd.instr  = i;
        cmd.period = p;
        cmd.count  = c;
        cmd.width  = w;
        fifoQ.push_back(cmd);
        modelQ.push_back(cmd);
        remove_buffer_empty = 1'b0;
    endtask

    // One command becomes FETCH, LOAD, then count*period RUN cycles.
    task automatic expandCmd(input cmd_t c);
        cyc_t   e;
        longint pe;
        longint we;
        longint n;
        e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        expQ.push_back(e);
        e = '{1'b1, 1'b0, 1'b0, (c.count == 0), 1'b1, c.instr[0]};
        expQ.push_back(e);
        pe = (c.period == 0) ? 1 : longint'(c.period);
        we = (longint'(c.width) < pe) ? longint'(c.width) : pe - 1;
        n  = longint'(c.count) * pe;
        for (longint k = 0; k < n; k++) begin
            e = '{1'b1, 1'b0, (c.instr[1] && ((k % pe) < we)), (k == n - 1), 1'b0, 1'b0};
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus();
        cyc_t cur;
        cmd_t c;
        logic rsSeen;
        @(negedge clock);
        if (expQ.size() > 0) cur = expQ.pop_front();
        else                 cur = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checkOutput("busy", busy, cur.busy);
        checkOutput("remove_signal", remove_signal, cur.rs);
        checkOutput("pulse_out", pulse_out, cur.pulse);
        checkOutput("command_done", command_done, cur.done);
        checkOutput("direction_out", direction_out, expDir);
        checkOutput("underrun", underrun, expUnder);
`ifdef COMMAND_EXECUTOR_POSITION_EN
        checkOutput("position", position, expPos);
        if (cur.pulse && !prevExpPulse) expPos = expDir ? expPos - 1 : expPos + 1;
        prevExpPulse = cur.pulse;
`endif
        if (cur.done) doneSeen++;
        rsSeen = remove_signal;
        if (reset) begin
            expQ.delete();
            expDir       = 1'b0;
            expUnder     = 1'b0;
            expPos       = 0;
            prevExpPulse = 1'b0;
        end else begin
            if (cur.setDir) expDir = cur.dirVal;
            if (cur.done && enable && modelQ.size() == 0) expUnder = 1'b1;
            else if (clear_status)                        expUnder = 1'b0;
            if (expQ.size() == 0 && enable && modelQ.size() > 0) expandCmd(modelQ.pop_front());
        end
        @(posedge clock);
        #1;
        if (rsSeen && fifoQ.size() > 0) begin
            c = fifoQ.pop_front();
            remove_instruction  = c.instr;
            remove_pulse_period = c.period;
            remove_pulse_count  = c.count;
            remove_pulse_width  = c.width;
        end
        remove_buffer_empty = (fifoQ.size() == 0);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        while ((expQ.size() > 0 || (enable && modelQ.size() > 0)) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("idle_timeout", (n < budget), 1'b1);
        runCycles(2);
    endtask

    initial begin
        int d0;
        reset               = 1'b1;
        enable              = 1'b0;
        clear_status        = 1'b0;
        remove_buffer_empty = 1'b1;
        remove_instruction  = '0;
        remove_pulse_period = '0;
        remove_pulse_count  = '0;
        remove_pulse_width  = '0;
        repeat (2) @(posedge clock);
        #1;
        applyStimulus();
        reset = 1'b0;
        runCycles(2);

        // Single PULSE command, then starvation raises underrun.
        enable = 1'b1;
        pushCmd(4'd2, 32'd4, 32'd4, 32'd1);
        runUntilIdle(200);
        checkOutput("underrun_after_first", underrun, 1'b1);
        clear_status = 1'b1;
        applyStimulus();
        clear_status = 1'b0;
        checkOutput("underrun_cleared", underrun, 1'b0);

        // Reverse direction with width clamped to period-1.
        pushCmd(4'd3, 32'd4, 32'd16, 32'd4);
        runUntilIdle(200);
        checkOutput("direction_held", direction_out, 1'b1);

        // Two queued dwells run back to back.
        d0 = doneSeen;
        pushCmd(4'd0, 32'd4, 32'd16, 32'd4);
        pushCmd(4'd0, 32'd4, 32'd16, 32'd4);
        runUntilIdle(400);
        checkOutput("dwell_done_count", doneSeen - d0, 32'd2);

        // Zero count completes in LOAD.
        pushCmd(4'd2, 32'd0, 32'd0, 32'd5);
        runUntilIdle(50);

        // Clear coinciding with a new underrun: set must win.
        pushCmd(4'd2, 32'd2, 32'd2, 32'd1);
        for (int i = 0; i < 50 && !(expQ.size() == 1 && expQ[0].done); i++) applyStimulus();
        clear_status = 1'b1;
        applyStimulus();
        clear_status = 1'b0;
        checkOutput("set_beats_clear", underrun, 1'b1);

        // Enable dropped mid-command: finish, then stay idle despite queued work.
        pushCmd(4'd2, 32'd3, 32'd5, 32'd1);
        pushCmd(4'd3, 32'd2, 32'd2, 32'd1);
        runCycles(6);
        enable = 1'b0;
        runUntilIdle(100);
        runCycles(3);
        checkOutput("idle_when_disabled", busy, 1'b0);
        enable = 1'b1;
        runUntilIdle(100);

        // Reset in the middle of RUN aborts without a completion strobe.
        pushCmd(4'd2, 32'd4, 32'd4, 32'd1);
        runCycles(8);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("post_reset_busy", busy, 1'b0);
        checkOutput("post_reset_underrun", underrun, 1'b0);
        runCycles(3);

        // Random commands with random enable and clear activity.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) != 0)
                pushCmd(4'($urandom_range(0, 15)), 32'($urandom_range(0, 5)),
                        32'($urandom_range(0, 5)), 32'($urandom_range(0, 6)));
            enable       = ($urandom_range(0, 7) != 0);
            clear_status = ($urandom_range(0, 7) == 0);
            runCycles($urandom_range(1, 15));
            clear_status = 1'b0;
        end
        enable = 1'b1;
        runUntilIdle(5000);

`ifdef COMMAND_EXECUTOR_POSITION_EN
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        pushCmd(4'd2, 32'd4, 32'd4, 32'd1);
        runUntilIdle(200);
        checkOutput("position_fwd", position, 32'd4);
        pushCmd(4'd3, 32'd4, 32'd16, 32'd1);
        runUntilIdle(200);
        checkOutput("position_rev", position, 32'hFFFF_FFF4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
